// File: rtl/line_buf_pkg.sv
// Shared helpers for the line ring buffer: width arithmetic, the LINES sanity
// check and the occupancy-counter operation type.
package line_buf_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } count_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A single-bit slot pointer is the minimum, so one line can fill while another is read.
    function automatic bit lines_ok(input int lines);
        return (lines >= 2) && ((lines & (lines - 1)) == 0);
    endfunction

    function automatic int slot_width(input int lines);
        return clog2(lines);
    endfunction

    function automatic int count_width(input int lines);
        return clog2(lines) + 1;
    endfunction

    localparam int DEFAULT_LINES   = 4;
    localparam int DEFAULT_SLOT_W  = slot_width(DEFAULT_LINES);
    localparam int DEFAULT_COUNT_W = count_width(DEFAULT_LINES);

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// The array itself is never reset; only the read register is.
module sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_ring_buffer.sv
// Circular multi-line store: streaming line writer with end-of-line commit and a
// random-access reader addressing committed lines relative to the oldest one.
module line_ring_buffer
    import line_buf_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    parameter int LINES         = 4,
    parameter int OUTPUT_REG    = 0,
    localparam int SLOT_W       = slot_width(LINES),
    localparam int COUNT_W      = count_width(LINES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_eol,
    output logic                     wr_ready,
    input  logic                     rd_req,
    input  logic [SLOT_W-1:0]        rd_line,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_err,
    input  logic                     release_line,
    output logic [COUNT_W-1:0]       line_count,
    output logic [ADDRESS_WIDTH:0]   oldest_len,
    output logic                     overflow
);

    localparam int RAM_AW = SLOT_W + ADDRESS_WIDTH;

    if (!lines_ok(LINES)) begin : g_bad_lines
        $error("line_ring_buffer: LINES must be a power of two and at least 2");
    end

    logic [SLOT_W-1:0]        wr_slot;
    logic [SLOT_W-1:0]        rd_slot;
    logic [ADDRESS_WIDTH-1:0] wr_x;
    logic [ADDRESS_WIDTH:0]   len_q [LINES];

    logic      accept;
    logic      at_max;
    logic      commit;
    logic      do_release;
    count_op_e count_op;

    logic [SLOT_W-1:0]     rd_sel_slot;
    logic                  rd_err_now;
    logic                  rd_v1;
    logic                  rd_e1;
    logic [DATA_WIDTH-1:0] ram_q;

    assign wr_ready   = (line_count < COUNT_W'(LINES));
    assign accept     = wr_valid && wr_ready;
    assign at_max     = &wr_x;
    assign commit     = accept && (wr_eol || at_max);
    assign do_release = release_line && (line_count != '0);

    // Commit and release together leave occupancy unchanged while both pointers move.
    always_comb begin
        count_op = CNT_HOLD;
        case ({commit, do_release})
            2'b10:   count_op = CNT_INC;
            2'b01:   count_op = CNT_DEC;
            default: count_op = CNT_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_slot    <= '0;
            rd_slot    <= '0;
            wr_x       <= '0;
            line_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                if (commit) begin
                    wr_slot <= wr_slot + 1'b1;
                    wr_x    <= '0;
                end else begin
                    wr_x <= wr_x + 1'b1;
                end
                if (at_max && !wr_eol) begin
                    overflow <= 1'b1;
                end
            end
            if (do_release) begin
                rd_slot <= rd_slot + 1'b1;
            end
            case (count_op)
                CNT_INC: line_count <= line_count + 1'b1;
                CNT_DEC: line_count <= line_count - 1'b1;
                default: line_count <= line_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            len_q[wr_slot] <= (ADDRESS_WIDTH + 1)'(wr_x) + 1'b1;
        end
    end

    assign oldest_len = (line_count != '0) ? len_q[rd_slot] : '0;

    // Reads resolve against the pre-release oldest slot of this cycle.
    assign rd_sel_slot = rd_slot + rd_line;
    assign rd_err_now  = ({1'b0, rd_line} >= line_count);

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_addr ({wr_slot, wr_x}),
        .wr_data (wr_data),
        .rd_en   (rd_req),
        .rd_addr ({rd_sel_slot, rd_addr}),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1 <= 1'b0;
            rd_e1 <= 1'b0;
        end else begin
            rd_v1 <= rd_req;
            rd_e1 <= rd_req && rd_err_now;
        end
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic                  rd_v2;
        logic                  rd_e2;
        logic [DATA_WIDTH-1:0] rd_d2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_v2 <= 1'b0;
                rd_e2 <= 1'b0;
                rd_d2 <= '0;
            end else begin
                rd_v2 <= rd_v1;
                rd_e2 <= rd_e1;
                if (rd_v1) begin
                    rd_d2 <= ram_q;
                end
            end
        end

        assign rd_valid = rd_v2;
        assign rd_err   = rd_e2;
        assign rd_data  = rd_d2;
    end else begin : g_no_out_reg
        assign rd_valid = rd_v1;
        assign rd_err   = rd_e1;
        assign rd_data  = ram_q;
    end

endmodule

// File: tb/tb_line_ring_buffer.sv
// Drives two line_ring_buffer instances (latency 1 and latency 2) with identical
// stimulus and compares them against a behavioural model and read scoreboard.
module tb_line_ring_buffer;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int NL    = 4;
    localparam int MAXX  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_eol = 1'b0;
    logic          rd_req = 1'b0;
    logic [1:0]    rd_line = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          release_line = 1'b0;

    logic          wr_ready0, wr_ready1;
    logic          rd_valid0, rd_valid1;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_err0, rd_err1;
    logic [2:0]    line_count0, line_count1;
    logic [AW:0]   oldest_len0, oldest_len1;
    logic          overflow0, overflow1;

    always #5 clk = ~clk;

    line_ring_buffer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LINES(NL), .OUTPUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_eol(wr_eol),
        .wr_ready(wr_ready0), .rd_req(rd_req), .rd_line(rd_line), .rd_addr(rd_addr),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_err(rd_err0), .release_line(release_line),
        .line_count(line_count0), .oldest_len(oldest_len0), .overflow(overflow0)
    );

    line_ring_buffer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LINES(NL), .OUTPUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_eol(wr_eol),
        .wr_ready(wr_ready1), .rd_req(rd_req), .rd_line(rd_line), .rd_addr(rd_addr),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_err(rd_err1), .release_line(release_line),
        .line_count(line_count1), .oldest_len(oldest_len1), .overflow(overflow1)
    );

    typedef struct {
        int            due;
        bit            err;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t q0[$];
    rd_exp_t q1[$];

    logic [DW-1:0] m_mem [NL][MAXX + 1];
    int m_len [NL];
    int m_wslot, m_rslot, m_wx, m_count;
    bit m_ovf;
    int cyc;
    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, actual, expected);
        end
    endtask

    task automatic resetModel();
        m_wslot = 0;
        m_rslot = 0;
        m_wx    = 0;
        m_count = 0;
        m_ovf   = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic checkState();
        int exp_len;
        exp_len = (m_count > 0) ? m_len[m_rslot] : 0;
        checkOutput("line_count0", line_count0, m_count);
        checkOutput("line_count1", line_count1, m_count);
        checkOutput("oldest_len0", oldest_len0, exp_len);
        checkOutput("oldest_len1", oldest_len1, exp_len);
        checkOutput("wr_ready0", wr_ready0, m_count < NL);
        checkOutput("wr_ready1", wr_ready1, m_count < NL);
        checkOutput("overflow0", overflow0, m_ovf);
        checkOutput("overflow1", overflow1, m_ovf);
    endtask

    task automatic checkReads();
        rd_exp_t e;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            checkOutput("rd_valid0", rd_valid0, 1);
            checkOutput("rd_err0", rd_err0, e.err);
            if (!e.err) checkOutput("rd_data0", rd_data0, e.data);
        end else begin
            checkOutput("rd_valid0_idle", rd_valid0, 0);
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            checkOutput("rd_valid1", rd_valid1, 1);
            checkOutput("rd_err1", rd_err1, e.err);
            if (!e.err) checkOutput("rd_data1", rd_data1, e.data);
        end else begin
            checkOutput("rd_valid1_idle", rd_valid1, 0);
        end
    endtask

    // Called at a falling edge: check what the last rising edge produced, then drive the next cycle.
    task automatic applyStimulus(input bit wv, input logic [DW-1:0] wd, input bit weol,
                                 input bit rreq, input int rline, input int raddr, input bit rel);
        rd_exp_t e;
        bit accept, commit, do_rel;
        checkState();
        checkReads();
        wr_valid     = wv;
        wr_data      = wd;
        wr_eol       = weol;
        rd_req       = rreq;
        rd_line      = rline[1:0];
        rd_addr      = raddr[AW-1:0];
        release_line = rel;
        if (rreq) begin
            e.err  = (rline >= m_count);
            e.data = m_mem[(m_rslot + rline) % NL][raddr];
            e.due  = cyc + 1;
            q0.push_back(e);
            e.due  = cyc + 2;
            q1.push_back(e);
        end
        accept = wv && (m_count < NL);
        commit = 1'b0;
        do_rel = rel && (m_count > 0);
        if (accept) begin
            m_mem[m_wslot][m_wx] = wd;
            if (weol || m_wx == MAXX) begin
                commit = 1'b1;
                if (!weol) m_ovf = 1'b1;
                m_len[m_wslot] = m_wx + 1;
                m_wslot = (m_wslot + 1) % NL;
                m_wx = 0;
            end else begin
                m_wx++;
            end
        end
        if (do_rel) m_rslot = (m_rslot + 1) % NL;
        m_count = m_count + int'(commit) - int'(do_rel);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writeLine(input int base, input int n, input bit eol_last);
        for (int i = 0; i < n; i++)
            applyStimulus(1, DW'(base + i), eol_last && (i == n - 1), 0, 0, 0, 0);
    endtask

    task automatic readPixel(input int line, input int addr);
        applyStimulus(0, 0, 0, 1, line, addr, 0);
    endtask

    task automatic releaseAll();
        for (int i = 0; i < 2 * NL && m_count > 0; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rline, raddr, slot;
        cyc = 0;
        resetModel();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single line, then a read of its third pixel.
        writeLine(10, 5, 1);
        readPixel(0, 2);
        idle(3);

        // Fill every slot, try a dropped pixel, then release and wrap into slot 0.
        writeLine(20, 3, 1);
        writeLine(30, 6, 1);
        writeLine(40, 7, 1);
        applyStimulus(1, 8'd99, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        writeLine(50, 7, 1);
        for (int a = 0; a < 7; a++) readPixel(3, a);
        idle(2);

        // Commit and release in the same cycle at two lines of occupancy.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        writeLine(60, 2, 0);
        applyStimulus(1, 8'd62, 1, 0, 0, 0, 1);
        idle(2);

        // Forced commit at maximum length, then the spill-over pixel starts a new line.
        releaseAll();
        writeLine(8'h80, 9, 0);
        applyStimulus(1, 8'h89, 1, 0, 0, 0, 0);
        for (int a = 0; a <= MAXX; a++) readPixel(0, a);
        readPixel(2, 0);
        idle(3);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        readPixel(2, 1);
        readPixel(0, 0);
        readPixel(0, 1);
        idle(3);

        // Random traffic; reads stay within committed line lengths.
        for (int i = 0; i < 200; i++) begin
            rline = $urandom_range(0, NL - 1);
            slot  = (m_rslot + rline) % NL;
            raddr = (rline < m_count) ? $urandom_range(0, m_len[slot] - 1) : $urandom_range(0, MAXX);
            applyStimulus($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1, rline, raddr, $urandom_range(0, 5) == 0);
        end
        idle(3);

        // Asynchronous reset in the middle of a line with three lines held.
        releaseAll();
        writeLine(8'hA0, 3, 1);
        writeLine(8'hB0, 2, 1);
        writeLine(8'hC0, 4, 1);
        writeLine(8'hD0, 2, 0);
        readPixel(0, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_line_count0", line_count0, 0);
        checkOutput("rst_line_count1", line_count1, 0);
        checkOutput("rst_oldest_len0", oldest_len0, 0);
        checkOutput("rst_wr_ready0", wr_ready0, 1);
        checkOutput("rst_overflow0", overflow0, 0);
        checkOutput("rst_overflow1", overflow1, 0);
        checkOutput("rst_rd_valid0", rd_valid0, 0);
        checkOutput("rst_rd_err0", rd_err0, 0);
        checkOutput("rst_rd_data0", rd_data0, 0);
        checkOutput("rst_rd_data1", rd_data1, 0);
        resetModel();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        writeLine(70, 4, 1);
        for (int a = 0; a < 4; a++) readPixel(0, a);
        idle(4);
        checkOutput("drain_q0", q0.size(), 0);
        checkOutput("drain_q1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
